// File: rtl/gate2_pkg.sv
// Shared definitions for the two-input gate self-test: FSM encoding, z bit
// positions and the golden output table indexed by {a,b}.
package gate2_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam int Z_W    = 6;
   localparam int Z_AND  = 0;
   localparam int Z_NAND = 1;
   localparam int Z_OR   = 2;
   localparam int Z_NOR  = 3;
   localparam int Z_XOR  = 4;
   localparam int Z_XNOR = 5;

   // Entry i is the fault-free z[5:0] for {a,b} = i.
   localparam logic [3:0][Z_W-1:0] EXP_Z = {
      6'b100101,   // 11
      6'b010110,   // 10
      6'b010110,   // 01
      6'b101010    // 00
   };

endpackage

// File: rtl/gate2_golden.sv
// Combinational reference model of the gate block: {a,b} -> expected z.
module gate2_golden
   import gate2_pkg::*;
(
   input  logic           a,
   input  logic           b,
   output logic [Z_W-1:0] z_exp
);

   always_comb begin
      z_exp = EXP_Z[{a, b}];
   end

endmodule

// File: rtl/gate2_bist.sv
// Self-test controller: walks {a,b} through 00..11, waits SETTLE_CYC cycles
// per vector, samples z once and accumulates mismatch results.
module gate2_bist
   import gate2_pkg::*;
#(
   parameter int SETTLE_CYC = 4,
   parameter int CNT_W      = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [Z_W-1:0] z,
   output logic           a,
   output logic           b,
   output logic           busy,
   output logic           done,
   output logic           pass,
   output logic [2:0]     err_count,
   output logic [3:0]     fail_vec,
   output logic [Z_W-1:0] fail_gate
);

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYC - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       idx_q, idx_d;
   logic             a_q, a_d, b_q, b_d;
   logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;
   logic [2:0]       err_q, err_d;
   logic [3:0]       fvec_q, fvec_d;
   logic [Z_W-1:0]   fgate_q, fgate_d;

   logic [Z_W-1:0]   z_exp;
   logic [Z_W-1:0]   mism;
   logic [2:0]       err_upd;

   gate2_golden u_golden (
      .a     (a_q),
      .b     (b_q),
      .z_exp (z_exp)
   );

   assign mism    = z ^ z_exp;
   assign err_upd = err_q + {2'b00, (mism != '0)};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      busy_d  = busy_q;
      done_d  = done_q;
      pass_d  = pass_q;
      err_d   = err_q;
      fvec_d  = fvec_q;
      fgate_d = fgate_q;
      case (state_q)
         IDLE, DONE: begin
            // A new run wipes every result of the previous one.
            if (start) begin
               state_d    = SETTLE;
               cnt_d      = CNT_LOAD;
               idx_d      = 2'd0;
               {a_d, b_d} = 2'b00;
               busy_d     = 1'b1;
               done_d     = 1'b0;
               pass_d     = 1'b0;
               err_d      = '0;
               fvec_d     = '0;
               fgate_d    = '0;
            end
         end
         SETTLE: begin
            if (cnt_q == '0) begin
               state_d = SAMPLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         SAMPLE: begin
            err_d = err_upd;
            if (mism != '0) begin
               fvec_d[idx_q] = 1'b1;
               fgate_d       = fgate_q | mism;
            end
            if (idx_q != 2'd3) begin
               idx_d      = idx_q + 2'd1;
               {a_d, b_d} = idx_q + 2'd1;
               cnt_d      = CNT_LOAD;
               state_d    = SETTLE;
            end else begin
               state_d = DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               pass_d  = (err_upd == '0);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         a_q     <= 1'b0;
         b_q     <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         err_q   <= '0;
         fvec_q  <= '0;
         fgate_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         err_q   <= err_d;
         fvec_q  <= fvec_d;
         fgate_q <= fgate_d;
      end
   end

   assign a         = a_q;
   assign b         = b_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign err_count = err_q;
   assign fail_vec  = fvec_q;
   assign fail_gate = fgate_q;

endmodule

// File: doc/gate2_bist.md
Name: gate2_bist

Overview:
- On-chip self-test controller for the two-input gate block.
- Drives the gate's a/b inputs through all four input vectors, in order 00, 01, 10, 11.
- Waits a programmable settle time per vector, then samples the gate's 6-bit z output and compares it against a golden model.
- Reports pass/fail, an error count, a per-vector fail mask and a sticky per-gate fail mask; intended for board-level LED readout.

Parameters:
- SETTLE_CYC, 4, clock cycles each vector is held before z is sampled; legal range 1..255.
- CNT_W, 8, width of the settle counter; must satisfy 2**CNT_W > SETTLE_CYC.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  level/pulse; sampled only in IDLE or DONE; launches a test run.
- z  input  6  gate outputs under test: z[0]=AND, z[1]=NAND, z[2]=OR, z[3]=NOR, z[4]=XOR, z[5]=XNOR.
- a  output  1  registered stimulus to gate input a.
- b  output  1  registered stimulus to gate input b.
- busy  output  1  high while a run is in progress.
- done  output  1  high from end of run until next accepted start.
- pass  output  1  valid when done=1; high iff err_count==0.
- err_count  output  3  number of failing vectors, 0..4.
- fail_vec  output  4  bit i set if vector i ({a,b}=i) mismatched.
- fail_gate  output  6  sticky OR of mismatch masks; bit k set if z[k] was ever wrong.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - a=b=0, busy=done=pass=0, err_count=0, fail_vec=0, fail_gate=0, settle counter=0, vector index=0.
  - Takes effect immediately, including mid-run; no partial results survive.
- States: IDLE, SETTLE, SAMPLE, DONE. All outputs are registered.
- IDLE:
  - On start=1: go to SETTLE.
  - Load {a,b}=2'b00, idx=0, cnt=SETTLE_CYC-1, busy=1, done=0, pass=0.
  - Clear err_count, fail_vec and fail_gate.
- SETTLE:
  - Decrement cnt each cycle.
  - When cnt==0, go to SAMPLE next cycle.
  - Occupies exactly SETTLE_CYC cycles.
- SAMPLE (1 cycle):
  - mism = z XOR expected({a,b}).
  - If mism!=0: err_count+=1, fail_vec[idx]=1, fail_gate|=mism.
  - If idx<3: idx+=1, {a,b}=idx+1, cnt=SETTLE_CYC-1, go to SETTLE.
  - If idx==3: go to DONE, busy=0, done=1, pass=(final error count==0). The final count includes the current vector.
- DONE:
  - Results and a/b (=2'b11) are held.
  - start=1 behaves exactly as start in IDLE: clears results and restarts.
- start while busy=1 is ignored; no restart, no effect on results.
- Latency: done rises exactly 4*(SETTLE_CYC+1) cycles after the edge that samples start.
  - Default: 20 cycles.
- Expected model, per {a,b}:
  - 00 -> 6'b101010
  - 01 -> 6'b010110
  - 10 -> 6'b010110
  - 11 -> 6'b100101
  - Bit order is z[5..0] = XNOR,XOR,NOR,OR,NAND,AND.
- z is sampled only in SAMPLE. Glitches during SETTLE are ignored.
- err_count cannot exceed 4; no wrap handling is needed.

Decomposition:
- Shared package gate2_pkg holds:
  - state encoding: IDLE=2'd0, SETTLE=2'd1, SAMPLE=2'd2, DONE=2'd3;
  - z bit index constants: Z_AND..Z_XNOR;
  - the 4-entry expected-z constant table.
- One sub-module, gate2_golden: purely combinational, ({a,b}) -> expected z[5:0].
  - The same sub-module is reused by benches as the reference model.
- FSM, counter and result registers live in gate2_bist.

Test Plan:
- Correct gate, SETTLE_CYC=4:
  - Pulse start for 1 cycle.
  - Required: busy high for 20 cycles; a/b step 00,01,10,11 every 5 cycles; done=1, pass=1, err_count=0, fail_vec=0, fail_gate=0.
- Faulty model with z[4] (XOR) stuck-at-0:
  - Required: err_count=2, fail_vec=4'b0110, fail_gate=6'b010000, pass=0.
- Faulty model with all z stuck at 6'b000000:
  - Required: err_count=4, fail_vec=4'b1111, fail_gate=6'b111111, pass=0.
- Restart behaviour:
  - Hold start=1 continuously from mid-run: ignored while busy; the run completes in 20 cycles.
  - Then, in DONE, the held start restarts: results clear, busy=1 next cycle.
- Reset mid-operation:
  - Assert rst_n=0 during vector 2's SETTLE: all outputs are 0 immediately, asynchronously.
  - After release, the block idles until start.
- SETTLE_CYC=1:
  - Run with a correct gate.
  - Required: done 8 cycles after start is sampled; pass=1.
